// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline memory stage: access FSM states,
// SRAM data width, default memory base and the byte-to-word address helper.
package arm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    localparam int MEM_BASE_DEFAULT = 1024;
    localparam int SRAM_DW          = 16;

    // 32-bit word index relative to the SRAM base; addresses below the base wrap.
    function automatic logic [29:0] word_of(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] offset;
        offset = addr - base;
        return offset[31:2];
    endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// SRAM access sequencer: splits one 32-bit access into low/high half-word
// phases of SRAM_WAIT cycles each, drives the SRAM pins and assembles load data.
module sram_ctrl
    import arm_pkg::*;
#(
    parameter int SRAM_WAIT = 2,
    parameter int ADDR_W    = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_store,
    input  logic                 is_load,
    input  logic [29:0]          word,
    input  logic [31:0]          wdata,
    input  logic                 hit_load,
    input  logic [31:0]          hit_data,
    output logic                 freeze,
    output logic                 idle,
    output logic                 hi_last,
    output logic [31:0]          mem_data,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [SRAM_DW-1:0]   sram_wdata,
    input  logic [SRAM_DW-1:0]   sram_rdata,
    output logic                 sram_we_n,
    output logic                 sram_oe_n
);

    localparam int CNT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);

    mem_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       mem_data_reg, mem_data_next;
    logic              seg_last;
    logic [ADDR_W-1:0] lo_addr, hi_addr;

    assign lo_addr  = ADDR_W'({word, 1'b0});
    assign hi_addr  = ADDR_W'({word, 1'b1});
    assign seg_last = (cnt_reg == CNT_LAST);
    assign idle     = (state_reg == ST_IDLE);
    assign mem_data = mem_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            mem_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            mem_data_reg <= mem_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        mem_data_next = mem_data_reg;
        freeze        = 1'b0;
        hi_last       = 1'b0;
        sram_addr     = '0;
        sram_wdata    = '0;
        sram_we_n     = 1'b1;
        sram_oe_n     = 1'b1;

        if (hit_load) begin
            mem_data_next = hit_data;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    freeze     = 1'b1;
                    state_next = ST_LO;
                    cnt_next   = '0;
                end
            end
            ST_LO: begin
                freeze     = 1'b1;
                sram_addr  = lo_addr;
                sram_wdata = wdata[15:0];
                // Releasing we_n one cycle early keeps data stable across the write edge.
                sram_we_n  = ~(is_store & ~seg_last);
                sram_oe_n  = ~is_load;
                if (seg_last) begin
                    state_next = ST_HI;
                    cnt_next   = '0;
                    if (is_load) begin
                        mem_data_next[15:0] = sram_rdata;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_HI: begin
                freeze     = 1'b1;
                sram_addr  = hi_addr;
                sram_wdata = wdata[31:16];
                sram_we_n  = ~(is_store & ~seg_last);
                sram_oe_n  = ~is_load;
                if (seg_last) begin
                    hi_last    = 1'b1;
                    state_next = ST_DONE;
                    cnt_next   = '0;
                    if (is_load) begin
                        mem_data_next[31:16] = sram_rdata;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A block held in reset never stalls the pipeline.
        if (rst) begin
            freeze = 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// ARM MEM stage: EXE/MEM pass-throughs plus 32-bit LDR/STR over a 16-bit SRAM.
// Optional one-entry last-load buffer enabled by defining MEM_READ_BUF_EN.
module mem_stage
    import arm_pkg::*;
#(
    parameter int SRAM_WAIT = 2,
    parameter int MEM_BASE  = MEM_BASE_DEFAULT,
    parameter int ADDR_W    = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_en_in,
    input  logic                mem_r_en_in,
    input  logic                mem_w_en_in,
    input  logic [31:0]         alu_result,
    input  logic [31:0]         val_rm,
    input  logic [3:0]          dest_in,
    output logic                wb_en,
    output logic                mem_r_en,
    output logic [31:0]         alu_result_out,
    output logic [3:0]          dest,
    output logic [31:0]         mem_data,
    output logic                freeze,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]  sram_wdata,
    input  logic [SRAM_DW-1:0]  sram_rdata,
    output logic                sram_we_n,
    output logic                sram_oe_n
);

    logic        req;
    logic        is_store;
    logic        is_load;
    logic        start;
    logic        hit;
    logic [31:0] hit_data;
    logic [29:0] word;
    logic        idle;
    logic        hi_last;

    assign wb_en          = wb_en_in;
    assign mem_r_en       = mem_r_en_in;
    assign alu_result_out = alu_result;
    assign dest           = dest_in;

    // Both enables together is an illegal decode and is executed as a store.
    assign req      = mem_r_en_in | mem_w_en_in;
    assign is_store = mem_w_en_in;
    assign is_load  = mem_r_en_in & ~mem_w_en_in;
    assign word     = word_of(alu_result, 32'(MEM_BASE));
    assign start    = req & ~hit;

`ifdef MEM_READ_BUF_EN
    logic        buf_valid_reg;
    logic [29:0] buf_word_reg;
    logic [31:0] buf_data_reg;

    assign hit      = idle & is_load & buf_valid_reg & (buf_word_reg == word);
    assign hit_data = buf_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_reg <= 1'b0;
            buf_word_reg  <= '0;
            buf_data_reg  <= '0;
        end else if (hi_last) begin
            if (is_load) begin
                buf_valid_reg <= 1'b1;
                buf_word_reg  <= word;
                buf_data_reg  <= {sram_rdata, mem_data[15:0]};
            end else if (is_store && buf_word_reg == word) begin
                buf_data_reg  <= val_rm;
            end
        end
    end
`else
    logic unused_ctrl;

    assign hit         = 1'b0;
    assign hit_data    = '0;
    assign unused_ctrl = ^{idle, hi_last};
`endif

    sram_ctrl #(
        .SRAM_WAIT (SRAM_WAIT),
        .ADDR_W    (ADDR_W)
    ) u_sram_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .is_load    (is_load),
        .word       (word),
        .wdata      (val_rm),
        .hit_load   (hit),
        .hit_data   (hit_data),
        .freeze     (freeze),
        .idle       (idle),
        .hi_last    (hi_last),
        .mem_data   (mem_data),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

endmodule
